sprite_render_sched: RTL

Parametrised draw/erase sequencer for N on-screen objects (paddles, puck, markers) sharing one VGA write port. Each frame it walks every object through a draw pass, holds for a programmable frame interval with its own internal counter, walks every object through an erase pass in background colour, then pulses a position-update strobe. It sits between the per-object datapaths (which own the x/y raster counters) and the VGA adapter's write interface. It generalises the two-paddle animation controller to N objects, per-object colours, pause, and optional object masking.

---
 rtl/sprite_render_sched.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sprite_render_sched.sv
`default_nettype none
// ============================================================================
// Module   : sprite_render_sched
// Purpose  : Draw/wait/erase/update sequencer for N_OBJ objects sharing one
//            VGA write port. Optional object masking: RENDER_SCHED_MASK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sprite_render_sched #(
  parameter int N_OBJ = 4,
  parameter int CW = 3,
  parameter int FRAME_CYCLES = 833334,
  parameter int FCW = 20,
  parameter logic [CW-1:0] BG_COLOUR = '0,
  localparam int IW = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N_OBJ-1:0]  obj_done,
  input  logic [N_OBJ*CW-1:0] obj_colour,
  input  logic [N_OBJ-1:0]  obj_active,
  input  logic              pause,
  output logic [N_OBJ-1:0]  draw_en,
  output logic [IW-1:0]     obj_sel,
  output logic              write_en,
  output logic [CW-1:0]     colour,
  output logic              erase,
  output logic              update
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAW   = 3'd1,
    S_WAIT   = 3'd2,
    S_ERASE  = 3'd3,
    S_UPDATE = 3'd4
  } state_t;

  localparam logic [IW-1:0]  c_last = IW'(N_OBJ - 1);
  localparam logic [FCW-1:0] c_fmax = FCW'(FRAME_CYCLES - 1);

  state_t         r_state;
  logic [IW-1:0]  r_idx;
  logic [FCW-1:0] r_fcnt;
  logic           w_skip;
  logic           w_adv;

`ifdef RENDER_SCHED_MASK_EN
  assign w_skip = ~obj_active[r_idx];
`else
  logic w_unused_active;
  assign w_unused_active = ^obj_active;
  assign w_skip = 1'b0;
`endif

  // A masked object is treated exactly like one whose raster just finished.
  assign w_adv = obj_done[r_idx] | w_skip;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_fcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_DRAW;
        S_DRAW, S_ERASE: begin
          if (w_adv) begin
            if (r_idx == c_last) begin
              r_idx   <= '0;
              r_state <= (r_state == S_DRAW) ? S_WAIT : S_UPDATE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (r_fcnt == c_fmax) begin
            if (!pause) begin
              r_state <= S_ERASE;
              r_fcnt  <= '0;
            end
          end else begin
            r_fcnt <= r_fcnt + 1'b1;
          end
        end
        S_UPDATE: begin
          r_state <= S_DRAW;
          r_idx   <= '0;
        end
        default: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
          r_fcnt  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    draw_en  = '0;
    write_en = 1'b0;
    colour   = '0;
    erase    = 1'b0;
    update   = 1'b0;
    obj_sel  = r_idx;
    case (r_state)
      S_DRAW, S_ERASE: begin
        if (w_skip) begin
          colour = BG_COLOUR;
        end else begin
          draw_en  = N_OBJ'(1) << r_idx;
          write_en = 1'b1;
          erase    = (r_state == S_ERASE);
          colour   = (r_state == S_ERASE) ? BG_COLOUR : obj_colour[r_idx*CW +: CW];
        end
      end
      S_UPDATE: update = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire
